// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memory command encoding,
// lock FSM states, request record and default widths.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic                   we;
    logic                   lock;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant: a held lock pins the grant to its owner,
// otherwise a lone request wins and a tie goes to the round-robin pointer.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr,
  input  logic       locked,
  input  logic       owner,
  output logic [1:0] grant
);

  // Grant selection
  always_comb begin
    grant = 2'b00;
    if (locked) begin
      grant = valid & port_onehot(owner);
    end else if (valid == 2'b11) begin
      grant = port_onehot(rr);
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer for a single-port data memory:
// accept in T, registered memory command in T+1, response pulse in T+2.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_lock,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_e       state_q;
  logic              owner_q;
  logic              rr_q;
  logic [CNT_W-1:0]  lock_cnt_q;
  logic [CNT_W-1:0]  cnt_inc;

  logic [1:0]        grant;
  logic [1:0]        acc;
  logic              acc_any;
  logic              acc_idx;
  logic              oth_valid;
  logic              cap_hit;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              mem_rw_d, mem_rw_q;
  logic              mem_tag_d, mem_tag_q;
  logic              mem_vld_d, mem_vld_q;
  logic [1:0]        resp_valid_d, resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_d, resp_rdata_q;

  rr_arb2 u_arb (
    .valid  (req_valid),
    .rr     (rr_q),
    .locked (state_q == LOCKED),
    .owner  (owner_q),
    .grant  (grant)
  );

  // No grant may escape while the block is held in reset.
  assign req_ready = grant & {2{rst_n}};
  assign acc       = req_valid & req_ready;
  assign acc_any   = |acc;
  assign acc_idx   = acc[1];
  assign oth_valid = req_valid[~acc_idx];
  assign sel_we    = req_we[acc_idx];
  assign sel_lock  = req_lock[acc_idx];
  assign sel_addr  = acc_idx ? req_addr1 : req_addr0;
  assign sel_wdata = acc_idx ? req_wdata1 : req_wdata0;

  // Grants only count against the cap while the other side is actually waiting.
  assign cnt_inc = lock_cnt_q + CNT_W'(oth_valid);
  assign cap_hit = oth_valid & (cnt_inc >= CNT_W'(LOCK_MAX));

  // Lock FSM together with the round-robin pointer and the lock counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      lock_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (acc_any) begin
        rr_q <= ~acc_idx;
      end
      case (state_q)
        UNLOCKED: begin
          if (acc_any && sel_lock && !cap_hit) begin
            state_q    <= LOCKED;
            owner_q    <= acc_idx;
            lock_cnt_q <= cnt_inc;
          end
        end
        LOCKED: begin
          if (acc_any) begin
            if (!sel_lock || cap_hit) begin
              state_q    <= UNLOCKED;
              lock_cnt_q <= {CNT_W{1'b0}};
            end else begin
              lock_cnt_q <= cnt_inc;
            end
          end else if (!req_valid[owner_q]) begin
            // Owner went idle: hand the next tie to the requester that was shut out.
            state_q    <= UNLOCKED;
            lock_cnt_q <= {CNT_W{1'b0}};
            rr_q       <= ~owner_q;
          end
        end
        default: begin
          state_q    <= UNLOCKED;
          lock_cnt_q <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Next memory command and response
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rw_d     = MEM_READ;
    mem_tag_d    = mem_tag_q;
    mem_vld_d    = 1'b0;
    resp_valid_d = 2'b00;
    resp_rdata_d = {DATA_W{1'b0}};
    if (acc_any) begin
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      mem_rw_d    = sel_we ? MEM_WRITE : MEM_READ;
      mem_tag_d   = acc_idx;
      mem_vld_d   = 1'b1;
    end else begin
      mem_rw_d    = MEM_READ;
    end
    if (mem_vld_q) begin
      resp_valid_d = port_onehot(mem_tag_q);
      if (mem_rw_q == MEM_READ) begin
        resp_rdata_d = mem_rdata;
      end else begin
        resp_rdata_d = {DATA_W{1'b0}};
      end
    end else begin
      resp_valid_d = 2'b00;
    end
  end

  // Memory and response stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      mem_rw_q     <= MEM_READ;
      mem_tag_q    <= 1'b0;
      mem_vld_q    <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rw_q     <= mem_rw_d;
      mem_tag_q    <= mem_tag_d;
      mem_vld_q    <= mem_vld_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rw     = mem_rw_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model with its own shadow memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, req_we, req_lock, resp_valid;
  logic [AW-1:0] req_addr0, req_addr1, mem_addr;
  logic [DW-1:0] req_wdata0, req_wdata1, resp_rdata, mem_wdata, mem_rdata;
  logic          mem_rw;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  // Single-port memory the DUT drives
  logic [31:0] mem [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_rw == MEM_WRITE) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } resp_t;
  resp_t       rq[$];
  logic [31:0] ref_mem [0:255] = '{default: 32'h0};
  int          m_rr, m_locked, m_owner, m_cnt;
  logic        exp_mrw;
  logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
  logic [1:0]  exp_ready, exp_rvalid;

  dmem_req_t idle_req;

  function automatic dmem_req_t mk(input logic we, input logic lock,
                                   input logic [31:0] addr, input logic [31:0] wdata);
    dmem_req_t r;
    r.we = we; r.lock = lock; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic drive(input logic [1:0] v, input dmem_req_t a, input dmem_req_t b);
    req_valid  = v;
    req_we     = {b.we, a.we};
    req_lock   = {b.lock, a.lock};
    req_addr0  = a.addr;
    req_addr1  = b.addr;
    req_wdata0 = a.wdata;
    req_wdata1 = b.wdata;
  endtask

  task automatic model_reset();
    m_rr = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
    rq.delete();
    exp_mrw = 1'b1; exp_maddr = 32'h0; exp_mwdata = 32'h0;
  endtask

  // At the falling edge: work out which requester should be granted and which response is due now.
  task automatic sample_phase();
    resp_t r;
    @(negedge clk);
    exp_ready = 2'b00;
    if (rst_n) begin
      if (m_locked != 0) begin
        if (req_valid[m_owner]) exp_ready = (m_owner == 1) ? 2'b10 : 2'b01;
      end else if (req_valid == 2'b11) begin
        exp_ready = (m_rr == 1) ? 2'b10 : 2'b01;
      end else begin
        exp_ready = req_valid;
      end
    end
    exp_rvalid = 2'b00;
    exp_rdata  = 32'h0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      exp_rvalid = (r.port == 1) ? 2'b10 : 2'b01;
      exp_rdata  = r.data;
    end
  endtask

  // Apply the expected accept to the model, then step to just after the next rising edge.
  task automatic advance();
    int i, o;
    logic [31:0] a, d;
    if (exp_ready != 2'b00) begin
      i = exp_ready[1] ? 1 : 0;
      o = 1 - i;
      a = (i == 1) ? req_addr1 : req_addr0;
      d = (i == 1) ? req_wdata1 : req_wdata0;
      if (req_we[i]) begin
        ref_mem[a[7:0]] = d;
        rq.push_back('{cyc + 2, i, 32'h0});
      end else begin
        rq.push_back('{cyc + 2, i, ref_mem[a[7:0]]});
      end
      exp_mrw = ~req_we[i]; exp_maddr = a; exp_mwdata = d;
      m_rr = o;
      if (m_locked != 0) begin
        if (!req_lock[i]) begin
          m_locked = 0; m_cnt = 0;
        end else if (req_valid[o]) begin
          m_cnt++;
          if (m_cnt >= LM) begin m_locked = 0; m_cnt = 0; end
        end
      end else if (req_lock[i]) begin
        m_locked = 1; m_owner = i; m_cnt = req_valid[o] ? 1 : 0;
        if (req_valid[o] && m_cnt >= LM) begin m_locked = 0; m_cnt = 0; end
      end
    end else begin
      exp_mrw = 1'b1;
      if (m_locked != 0 && !req_valid[m_owner]) begin
        m_locked = 0; m_cnt = 0; m_rr = 1 - m_owner;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b11, mk(1'b1, 1'b0, 32'h4, 32'h1), mk(1'b0, 1'b0, 32'h5, 32'h2));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL reset_mem_rw: got %b want 1", mem_rw); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_lines: addr %h wdata %h want 0", mem_addr, mem_wdata); end
    checks++; if (resp_valid !== 2'b00 || resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp: valid %b rdata %h want 0", resp_valid, resp_rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(2'b00, idle_req, idle_req);
  endtask

  task automatic test_write_read();
    drive(2'b01, mk(1'b1, 1'b0, 32'h4, 32'hDEADBEEF), idle_req);
    sample_phase();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_grant: got %b want 01", req_ready); end
    advance();
    drive(2'b01, mk(1'b0, 1'b0, 32'h4, 32'h0), idle_req);
    sample_phase();
    checks++; if (mem_rw !== 1'b0 || mem_addr !== 32'h4 || mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_mem_cycle: rw %b addr %h wdata %h want 0/4/deadbeef", mem_rw, mem_addr, mem_wdata); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b want 01", req_ready); end
    advance();
    drive(2'b00, idle_req, idle_req);
    sample_phase();
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_resp: valid %b rdata %h want 01/0", resp_valid, resp_rdata); end
    checks++; if (mem_rw !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL rd_mem_cycle: rw %b addr %h want 1/4", mem_rw, mem_addr); end
    advance();
    sample_phase();
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_after_wr: valid %b rdata %h want 01/deadbeef", resp_valid, resp_rdata); end
    advance();
  endtask

  task automatic test_alternate();
    logic [1:0] prev;
    drive(2'b11, mk(1'b1, 1'b0, 32'h1, 32'h000000A1), mk(1'b1, 1'b0, 32'h2, 32'h000000B2));
    repeat (2) begin sample_phase(); advance(); end
    drive(2'b11, mk(1'b0, 1'b0, 32'h1, 32'h0), mk(1'b0, 1'b0, 32'h2, 32'h0));
    prev = 2'b00;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) drive(2'b00, idle_req, idle_req);
      sample_phase();
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", k, req_ready, exp_ready); end
      if (k > 0 && k < 8) begin
        checks++; if (req_ready === prev) begin errors++; $display("FAIL alt_toggle[%0d]: got %b twice", k, req_ready); end
      end
      prev = req_ready;
      checks++; if (resp_valid !== exp_rvalid) begin errors++; $display("FAIL alt_resp_valid[%0d]: got %b want %b", k, resp_valid, exp_rvalid); end
      if (k >= 2 && resp_valid == 2'b01) begin
        checks++; if (resp_rdata !== 32'h000000A1) begin errors++; $display("FAIL alt_rdata0[%0d]: got %h want a1", k, resp_rdata); end
      end
      if (k >= 2 && resp_valid == 2'b10) begin
        checks++; if (resp_rdata !== 32'h000000B2) begin errors++; $display("FAIL alt_rdata1[%0d]: got %h want b2", k, resp_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_lock();
    int  g1;
    bit  got0;
    if (m_rr == 0) begin
      drive(2'b01, mk(1'b0, 1'b0, 32'h5, 32'h0), idle_req);
      sample_phase(); advance();
    end
    drive(2'b11, mk(1'b0, 1'b0, 32'h5, 32'h0), mk(1'b0, 1'b1, 32'h3, 32'h0));
    g1 = 0; got0 = 1'b0;
    for (int k = 0; k < 20 && !got0; k++) begin
      sample_phase();
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL lock_grant[%0d]: got %b want %b", k, req_ready, exp_ready); end
      if (req_ready == 2'b10) g1++;
      if (req_ready == 2'b01) got0 = 1'b1;
      advance();
    end
    checks++; if (!got0 || g1 != LM) begin errors++; $display("FAIL lock_cap: req1 grants %0d want %0d, req0 granted %0d want 1", g1, LM, got0); end
    drive(2'b00, idle_req, idle_req);
    repeat (3) begin sample_phase(); advance(); end
  endtask

  task automatic test_idle();
    int bad;
    drive(2'b10, idle_req, mk(1'b1, 1'b0, 32'h9, 32'hCAFEF00D));
    sample_phase(); advance();
    drive(2'b00, idle_req, idle_req);
    for (int k = 0; k < 10; k++) begin
      sample_phase();
      checks++; if (mem_rw !== ((k == 0) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL idle_mem_rw[%0d]: got %b want %b", k, mem_rw, (k == 0) ? 1'b0 : 1'b1); end
      advance();
    end
    checks++; if (mem[9] !== 32'hCAFEF00D) begin errors++; $display("FAIL idle_word: got %h want cafef00d", mem[9]); end
    bad = 0;
    for (int j = 0; j < 256; j++) if (mem[j] !== ref_mem[j]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_contents: %0d words differ want 0", bad); end
  endtask

  task automatic test_lock_drop();
    drive(2'b01, mk(1'b0, 1'b1, 32'h6, 32'h0), idle_req);
    sample_phase();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL drop_lock_grant: got %b want 01", req_ready); end
    advance();
    drive(2'b10, idle_req, mk(1'b0, 1'b0, 32'h7, 32'h0));
    sample_phase();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL drop_blocked: got %b want 00", req_ready); end
    advance();
    sample_phase();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL drop_release: got %b want 10", req_ready); end
    advance();
    drive(2'b00, idle_req, idle_req);
    repeat (3) begin sample_phase(); advance(); end
  endtask

  task automatic test_reset_midwrite();
    drive(2'b01, mk(1'b1, 1'b0, 32'h8, 32'h11112222), idle_req);
    sample_phase(); advance();
    drive(2'b00, idle_req, idle_req);
    repeat (3) begin sample_phase(); advance(); end
    // This write is aborted by reset, so it is deliberately kept out of the model.
    drive(2'b01, mk(1'b1, 1'b0, 32'h8, 32'h12345678), idle_req);
    @(posedge clk); #1;
    drive(2'b00, idle_req, idle_req);
    @(negedge clk);
    checks++; if (mem_rw !== 1'b0) begin errors++; $display("FAIL rst_wr_cycle: rw %b want 0", mem_rw); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL rst_async_rw: rw %b want 1", mem_rw); end
    @(posedge clk); #1;
    checks++; if (mem[8] !== 32'h11112222) begin errors++; $display("FAIL rst_word_kept: got %h want 11112222", mem[8]); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_resp: got %b want 00", resp_valid); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    dmem_req_t a, b;
    logic [1:0] v;
    for (int n = 0; n < 403; n++) begin
      v = (n < 400) ? 2'($urandom_range(0, 3)) : 2'b00;
      a = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 15)), $urandom);
      b = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 15)), $urandom);
      drive(v, a, b);
      sample_phase();
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", n, req_ready, exp_ready); end
      checks++; if (mem_rw !== exp_mrw || mem_addr !== exp_maddr || mem_wdata !== exp_mwdata) begin
        errors++; $display("FAIL rnd_mem[%0d]: rw/addr/wdata %b/%h/%h want %b/%h/%h", n, mem_rw, mem_addr, mem_wdata, exp_mrw, exp_maddr, exp_mwdata); end
      checks++; if (resp_valid !== exp_rvalid) begin errors++; $display("FAIL rnd_resp_valid[%0d]: got %b want %b", n, resp_valid, exp_rvalid); end
      if (exp_rvalid != 2'b00) begin
        checks++; if (resp_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, resp_rdata, exp_rdata); end
      end
      advance();
    end
  endtask

  initial begin
    idle_req = mk(1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    test_reset();
    test_write_read();
    test_alternate();
    test_lock();
    test_idle();
    test_lock_drop();
    test_reset_midwrite();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port data memory. Requester 0 (core load/store unit) and requester 1 (loader/DMA) issue valid/ready requests. The block grants one per cycle by round-robin, with an optional bounded lock for bursts. It drives the memory's shared address/write-data/read-write lines from registers and returns read data to the owning requester.

## Interface
- `ADDR_W`, 32, request/memory address width
- `DATA_W`, 32, data width
- `LOCK_MAX`, 16, maximum consecutive grants a locked requester may hold while the other requester waits (≥1)
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester request valid (bit i = requester i)
- `req_ready`  out  2  per-requester accept; at most one bit high
- `req_we`  in  2  per-requester 1 = write, 0 = read
- `req_lock`  in  2  per-requester: keep grant for the next request
- `req_addr0`, `req_addr1`  in  ADDR_W  request address
- `req_wdata0`, `req_wdata1`  in  DATA_W  write data
- `resp_valid`  out  2  one-cycle response pulse to the owner
- `resp_rdata`  out  DATA_W  read data (0 for write responses)
- `mem_addr`  out  ADDR_W  to memory address
- `mem_wdata`  out  DATA_W  to memory write data
- `mem_rw`  out  1  to memory: 1 = read, 0 = write (memory writes on rising edge while 0)
- `mem_rdata`  in  DATA_W  combinational read data from memory

## Operation
- Arbitration is combinational from `req_valid`, the round-robin pointer `rr` and the lock state. `req_ready[i]` is the grant.
- A request is accepted when `req_valid[i] & req_ready[i]`.
- Only one valid request: it is granted.
- Both requests valid, no lock: grant `rr`.
- After any accept by requester i, `rr` becomes `~i`.
- Lock:
  - An accepted request with `req_lock[i]=1` sets `owner=i` and `locked=1`.
  - While locked, only `owner` can be granted. The other requester sees `ready=0` even if the owner is idle.
  - Lock releases on any of:
    - an owner accept with `req_lock=0`
    - an owner `req_valid=0` for one cycle
    - `lock_cnt` reaching `LOCK_MAX` while the other requester is valid
  - On a forced release, the next grant goes to the waiting requester.
- `lock_cnt` increments on each owner accept while the other requester is valid. It clears on release.
- Memory stage register:
  - On accept, it loads `mem_addr`, `mem_wdata` and `mem_rw = ~req_we[i]`, plus the tag `i`.
  - With no accept, `mem_rw` returns to 1. `mem_addr`/`mem_wdata` hold.
  - With `mem_rw=1` held, an idle cycle never writes memory.
- Response register:
  - In the cycle after the memory cycle, `resp_valid[tag]` pulses for one cycle.
  - Reads: `resp_rdata` = `mem_rdata` sampled at the end of the memory cycle.
  - Writes: `resp_rdata` = 0.
- Responses have no backpressure. Requesters must consume them.
- Address and data pass through unmodified. No width arithmetic.

## Timing
- Accept in cycle T.
  - T+1: memory lines driven. A write commits at the end of T+1.
  - T+2: `resp_valid` pulses.
- Throughput is one access per cycle, fully pipelined. Back-to-back accepts by alternating requesters are allowed.
- A read in T+1 following a write to the same address in T returns the new data. The write has committed before the read cycle.
- Reset values:
  - `mem_rw=1`, `mem_addr=0`, `mem_wdata=0`
  - `resp_valid=0`, `resp_rdata=0`
  - `rr=0`, `locked=0`, `lock_cnt=0`
  - `req_ready` is 0 while `rst_n=0`.
- Reset mid-operation: `rst_n` low forces `mem_rw=1` asynchronously. An in-flight write is dropped. Pending responses are discarded.

## Structure
- Shared package (`dmem_pkg`) holds:
  - `MEM_READ=1'b1`, `MEM_WRITE=1'b0`
  - the request struct `{we, lock, addr, wdata}`
  - the `DATA_W`/`ADDR_W` defaults
- One sub-module, `rr_arb2`. It takes valid[1:0], `rr`, `locked` and `owner`, and produces the one-hot grant. It is purely combinational.
- The top holds the lock FSM (`UNLOCKED`, `LOCKED`), `lock_cnt`, the memory stage and the response stage.

## Test plan
- Req0 writes 0xDEADBEEF to addr 4 (accept T), then reads addr 4 (accept T+1):
  - `mem_rw=0` in T+1.
  - `resp_valid[0]` in T+2 with rdata=0.
  - `resp_valid[0]` in T+3 with rdata=0xDEADBEEF.
- Both valid continuously with reads to addr 1 and addr 2: grants alternate 0,1,0,1. Each requester receives its own data on the correct `resp_valid` bit.
- Req1 holds `req_lock=1` with back-to-back requests while req0 is valid, `LOCK_MAX=4`: req1 gets exactly 4 grants, then req0 is granted next.
- Idle bus for 10 cycles after a write: `mem_rw` stays 1 and the memory contents are unchanged.
- `rst_n` asserted low during the memory cycle of a write of 0x12345678:
  - `mem_rw` goes to 1 immediately.
  - The memory word keeps its old value.
  - `resp_valid=0`.
- Owner drops `req_valid` while locked, other requester valid: lock releases and the other requester is granted on the next cycle.
